uart_program_loader: RTL and testbench
======================================

# uart_program_loader

Parametrised UART program loader between the board RX pin and the CPU instruction memory. It deserialises 8-bit UART frames with optional parity and packs `INSTR_BYTES` consecutive bytes into one instruction word. Each word is written to sequential instruction-memory addresses. It declares the download complete after a configurable idle gap, then reports the last written address to the CPU start logic. It supersedes the fixed 2-byte / fixed-baud loader path.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200 baud); must be ≥ 4.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `INSTR_BYTES`, 2: bytes per instruction word, 1..4.
- `ADDR_W`, 8: memory address width.
- `BASE_ADDR`, 1: address of the first word.
- `DEPTH`, 255: number of writable words starting at `BASE_ADDR`.
- `IDLE_TIMEOUT_BITS`, 16: idle bit-times that end a download.
- `i_clk`, in, 1: sole clock.
- `i_rst_n`, in, 1: reset, asynchronous assert, active-low.
- `i_rx`, in, 1: UART line, idle high, asynchronous to `i_clk`.
- `i_clear`, in, 1: synchronous re-arm. Clears the counters, flags and done, and restarts at `BASE_ADDR`.
- `o_mem_we`, out, 1: one-cycle write strobe.
- `o_mem_addr`, out, `ADDR_W`: write address.
- `o_mem_wdata`, out, 8·`INSTR_BYTES`: write data.
- `o_transmit_done`, out, 1: download complete; held high until reset or `i_clear`.
- `o_max_addr`, out, `ADDR_W`: address of the last accepted write.
- `o_frame_err`, out, 1: sticky; a stop bit was sampled low.
- `o_parity_err`, out, 1: sticky; a parity mismatch occurred.
- `o_overflow`, out, 1: sticky; a word arrived after `DEPTH` writes.

## Operation
- Reset values: all outputs 0; `o_mem_addr` = 0; byte index 0; next address = `BASE_ADDR`.
- `i_rx` passes through a 2-flop synchroniser, preset to 1 at reset. All line references below mean the synchronised signal.
- RX state machine: IDLE → START → DATA → (PARITY) → STOP → IDLE.
  - IDLE → START on a synchronised falling edge.
  - START samples the line at `CLKS_PER_BIT/2`. If the line is high, it is a false start: return to IDLE with no side effects.
  - DATA samples 8 bits LSB-first, one every `CLKS_PER_BIT` from the start-bit midpoint.
  - PARITY state exists only when `PARITY` ≠ 0.
  - STOP samples one bit; no further stop bits are checked.
- Byte accepted: stop bit = 1 and parity correct.
  - Stop bit = 0: drop the byte, set `o_frame_err`, reset the byte index to 0 (discards the partial word).
  - Parity mismatch: same handling, but set `o_parity_err`.
  - If both errors occur, both flags set.
- Packing: the first byte of a word goes into the most significant byte of `o_mem_wdata`.
- When byte index `INSTR_BYTES-1` is accepted:
  - pulse `o_mem_we`;
  - set `o_max_addr` to the written address;
  - increment the next address;
  - reset the byte index to 0.
- Overflow: once `DEPTH` words are written, later completed words are not written (`o_mem_we` stays 0) and `o_overflow` is set. Addresses never wrap.
- Done: the idle counter runs while the RX FSM is in IDLE and the line is high. It clears on any start edge.
  - Counter reaching `IDLE_TIMEOUT_BITS`·`CLKS_PER_BIT` with ≥1 word written: set `o_transmit_done` and discard any partial word.
  - Timeout with 0 words written: done stays 0.
- After done, all RX activity is ignored (no writes, no flag changes) until `i_clear`.
- `i_clear` takes priority over everything in the same cycle. It restores the reset state except the synchroniser.
- Reset mid-frame aborts the frame immediately; nothing is written.

## Timing
- `o_mem_we` rises one cycle after the stop-bit sample of the word's last byte.
- `o_mem_addr`, `o_mem_wdata` and `o_max_addr` are registered with the strobe and are stable in that same cycle.
- `o_transmit_done` rises one cycle after the timeout count is reached.
- End-to-end latency from the `i_rx` falling edge to the stop-bit sample: 2 cycles of synchroniser + (9.5 + parity bit) · `CLKS_PER_BIT` ± 1.
- Back-to-back frames with a single stop bit are accepted: the FSM returns to IDLE at the stop-bit midpoint.

## Structure
- Shared package `cpu_loader_pkg`:
  - parity-mode constants `PAR_NONE`, `PAR_EVEN`, `PAR_ODD`;
  - RX state enum;
  - default `CLKS_PER_BIT` for the 100 MHz / 115200 baud configuration.
- One sub-module, `uart_rx_core`: synchroniser, RX state machine and parity check. It outputs `byte_valid`, `byte_data`, `frame_err`, `parity_err` and `line_idle`.
- The top level holds word packing, address/overflow logic, the idle timer and the done flag.

## Test plan
- Default parameters: send 0x41,0x26,0x81,0x80 … 0xE0,0x00 (22 bytes).
  - Expect 11 writes, addresses 1..11, first word 16'h4126, last word 16'hE000.
  - Expect `o_max_addr` = 11 and `o_transmit_done` high 16·868 cycles (+1) after the last stop bit.
- Drive `i_rx` low for 300 cycles, then high → no write, no flags, FSM back in IDLE.
- Send 0x41 with stop bit 0, then 0x41,0x00 → `o_frame_err` = 1 and exactly one write of 16'h4100 at address 1.
- `PARITY`=1: send 0x41 with a wrong parity bit, then a valid pair → `o_parity_err` = 1 and one write of the valid pair only.
- `DEPTH`=2: send 3 words → writes at addresses 1 and 2, `o_overflow` = 1, `o_max_addr` = 2, done asserts.
- Pulse `i_rst_n` low mid-byte, then send 0x41,0x00 → single write at address 1, done, `o_max_addr` = 1. Repeat with `i_clear` after done for identical results.

Source files
------------

// File: rtl/cpu_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_loader_pkg
// Description : Shared parity modes, RX state encoding and baud default for
//               the UART program loader.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_loader_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    // 100 MHz system clock, 115200 baud
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_core
// Description : Synchronised 8-bit UART receiver with optional parity check.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core
    import cpu_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned PARITY       = PAR_NONE
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       clear_i,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       frame_err_o,
    output logic       parity_err_o,
    output logic       line_idle_o
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_bit_q, par_bit_d;
    logic             w_bit_end;
    logic             w_par_bad;

    // Synchroniser presets to idle-high so reset never looks like a start edge
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
        end else if (clear_i) begin
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_bit_q <= par_bit_d;
        end
    end

    assign w_bit_end = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        w_par_bad = 1'b0;
        if (PARITY == PAR_EVEN) begin
            w_par_bad = (par_bit_q != (^shift_q));
        end else if (PARITY == PAR_ODD) begin
            w_par_bad = (par_bit_q == (^shift_q));
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        par_bit_d    = par_bit_q;
        byte_valid_o = 1'b0;
        frame_err_o  = 1'b0;
        parity_err_o = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT / 2 - 1)) begin
                    cnt_d   = '0;
                    state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (w_bit_end) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_PARITY: begin
                if (w_bit_end) begin
                    cnt_d     = '0;
                    par_bit_d = rx_sync_q;
                    state_d   = RX_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                // Leave at the stop-bit midpoint so back-to-back frames are caught
                if (w_bit_end) begin
                    cnt_d        = '0;
                    state_d      = RX_IDLE;
                    frame_err_o  = !rx_sync_q;
                    parity_err_o = w_par_bad;
                    byte_valid_o = rx_sync_q && !w_par_bad;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RX_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign byte_data_o = shift_q;
    assign line_idle_o = (state_q == RX_IDLE) && rx_sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_program_loader
// Description : Packs UART bytes into instruction words, writes them to
//               sequential memory addresses and flags download completion.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_program_loader
    import cpu_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT      = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned PARITY            = PAR_NONE,
    parameter int unsigned INSTR_BYTES       = 2,
    parameter int unsigned ADDR_W            = 8,
    parameter int unsigned BASE_ADDR         = 1,
    parameter int unsigned DEPTH             = 255,
    parameter int unsigned IDLE_TIMEOUT_BITS = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_rx,
    input  logic                     i_clear,
    output logic                     o_mem_we,
    output logic [ADDR_W-1:0]        o_mem_addr,
    output logic [8*INSTR_BYTES-1:0] o_mem_wdata,
    output logic                     o_transmit_done,
    output logic [ADDR_W-1:0]        o_max_addr,
    output logic                     o_frame_err,
    output logic                     o_parity_err,
    output logic                     o_overflow
);

    localparam int unsigned WORD_W  = 8 * INSTR_BYTES;
    localparam int unsigned TIMEOUT = IDLE_TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned IDLE_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned WCNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W   = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;

    logic              w_byte_valid, w_frame_err, w_parity_err, w_line_idle;
    logic [7:0]        w_byte_data;
    logic [WORD_W-1:0] w_word;

    logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic [WCNT_W-1:0] words_q, words_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [ADDR_W-1:0] max_addr_q, max_addr_d;
    logic              done_q, done_d;
    logic              frame_err_q, frame_err_d;
    logic              parity_err_q, parity_err_d;
    logic              overflow_q, overflow_d;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .PARITY       (PARITY)
    ) u_rx (
        .clk_i        (i_clk),
        .rst_n_i      (i_rst_n),
        .clear_i      (i_clear),
        .rx_i         (i_rx),
        .byte_valid_o (w_byte_valid),
        .byte_data_o  (w_byte_data),
        .frame_err_o  (w_frame_err),
        .parity_err_o (w_parity_err),
        .line_idle_o  (w_line_idle)
    );

    // Earlier bytes shift up, so the first byte of a word lands in the MSB
    assign w_word = (word_q << 8) | WORD_W'(w_byte_data);

    always_comb begin
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        next_addr_d  = next_addr_q;
        words_d      = words_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        max_addr_d   = max_addr_q;
        done_d       = done_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overflow_d   = overflow_q;

        if (!w_line_idle) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != IDLE_W'(TIMEOUT)) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end else begin
            idle_cnt_d = idle_cnt_q;
        end

        if (!done_q) begin
            if (w_frame_err) begin
                frame_err_d = 1'b1;
            end
            if (w_parity_err) begin
                parity_err_d = 1'b1;
            end
            if (w_frame_err || w_parity_err) begin
                byte_idx_d = '0;
            end
            if (w_byte_valid) begin
                word_d = w_word;
                if (byte_idx_q == IDX_W'(INSTR_BYTES - 1)) begin
                    byte_idx_d = '0;
                    if (words_q == WCNT_W'(DEPTH)) begin
                        overflow_d = 1'b1;
                    end else begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = next_addr_q;
                        mem_wdata_d = w_word;
                        max_addr_d  = next_addr_q;
                        next_addr_d = next_addr_q + 1'b1;
                        words_d     = words_q + 1'b1;
                    end
                end else begin
                    byte_idx_d = byte_idx_q + 1'b1;
                end
            end
            if ((idle_cnt_q == IDLE_W'(TIMEOUT)) && (words_q != '0)) begin
                done_d     = 1'b1;
                byte_idx_d = '0;
            end
        end

        if (i_clear) begin
            byte_idx_d   = '0;
            word_d       = '0;
            next_addr_d  = ADDR_W'(BASE_ADDR);
            words_d      = '0;
            idle_cnt_d   = '0;
            mem_we_d     = 1'b0;
            mem_addr_d   = '0;
            mem_wdata_d  = '0;
            max_addr_d   = '0;
            done_d       = 1'b0;
            frame_err_d  = 1'b0;
            parity_err_d = 1'b0;
            overflow_d   = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            byte_idx_q   <= '0;
            word_q       <= '0;
            next_addr_q  <= ADDR_W'(BASE_ADDR);
            words_q      <= '0;
            idle_cnt_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            max_addr_q   <= '0;
            done_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            next_addr_q  <= next_addr_d;
            words_q      <= words_d;
            idle_cnt_q   <= idle_cnt_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            max_addr_q   <= max_addr_d;
            done_q       <= done_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overflow_q   <= overflow_d;
        end
    end

    assign o_mem_we        = mem_we_q;
    assign o_mem_addr      = mem_addr_q;
    assign o_mem_wdata     = mem_wdata_q;
    assign o_transmit_done = done_q;
    assign o_max_addr      = max_addr_q;
    assign o_frame_err     = frame_err_q;
    assign o_parity_err    = parity_err_q;
    assign o_overflow      = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_program_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_program_loader
// Description : Directed bench for three loader configurations (plain,
//               even parity, two-word depth) against a word-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_program_loader;

    localparam int CPB  = 16;
    localparam int TOUT = 16 * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] rx;
    logic [2:0] clr;

    logic        we    [3];
    logic [7:0]  addr  [3];
    logic [15:0] wd    [3];
    logic        done  [3];
    logic [7:0]  maxa  [3];
    logic        ferr  [3];
    logic        perr  [3];
    logic        ovf   [3];

    always #5 clk = ~clk;

    // Instance 0: no parity; 1: even parity; 2: only two writable words
    for (genvar g = 0; g < 3; g++) begin : g_dut
        uart_program_loader #(
            .CLKS_PER_BIT      (CPB),
            .PARITY            ((g == 1) ? 1 : 0),
            .INSTR_BYTES       (2),
            .ADDR_W            (8),
            .BASE_ADDR         (1),
            .DEPTH             ((g == 2) ? 2 : 255),
            .IDLE_TIMEOUT_BITS (16)
        ) u_dut (
            .i_clk           (clk),
            .i_rst_n         (rst_n),
            .i_rx            (rx[g]),
            .i_clear         (clr[g]),
            .o_mem_we        (we[g]),
            .o_mem_addr      (addr[g]),
            .o_mem_wdata     (wd[g]),
            .o_transmit_done (done[g]),
            .o_max_addr      (maxa[g]),
            .o_frame_err     (ferr[g]),
            .o_parity_err    (perr[g]),
            .o_overflow      (ovf[g])
        );
    end

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Word-level model: bytes in, expected writes and flags out
    int          m_depth [3] = '{255, 255, 2};
    int          m_words [3];
    int          m_nb    [3];
    logic [7:0]  m_b0    [3];
    logic [7:0]  m_max   [3];
    bit          m_ferr  [3];
    bit          m_perr  [3];
    bit          m_ovf   [3];
    bit          m_done  [3];
    logic [25:0] exp_q[$];

    int          nwr     [3];
    int          last_we [3];
    logic [15:0] wlog    [3][32];

    logic [7:0] seq [22] = '{8'h41, 8'h26, 8'h81, 8'h80, 8'h12, 8'h34, 8'h56, 8'h78,
                             8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h01, 8'h02, 8'hA5, 8'h5A,
                             8'hFF, 8'h00, 8'h7E, 8'h81, 8'hE0, 8'h00};
    int base;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock; every write strobe seen is matched against the model queue
    task automatic tick();
        logic [25:0] e;
        @(negedge clk);
        cyc++;
        for (int u = 0; u < 3; u++) begin
            if (we[u] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL write_u%0d: got addr %h data %h, required no write", u, addr[u], wd[u]);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("write_u%0d", u), {6'd0, 2'(u), addr[u], wd[u]}, {6'd0, e});
                end
                if (nwr[u] < 32) wlog[u][nwr[u]] = wd[u];
                nwr[u]++;
                last_we[u] = cyc;
            end
        end
    endtask

    task automatic model_clear(input int u);
        m_words[u] = 0;
        m_nb[u]    = 0;
        m_b0[u]    = 8'h00;
        m_max[u]   = 8'h00;
        m_ferr[u]  = 1'b0;
        m_perr[u]  = 1'b0;
        m_ovf[u]   = 1'b0;
        m_done[u]  = 1'b0;
    endtask

    task automatic model_byte(input int u, input logic [7:0] d, input bit stop_ok, input bit par_bad);
        if (m_done[u]) return;
        if (!stop_ok || par_bad) begin
            if (!stop_ok) m_ferr[u] = 1'b1;
            if (par_bad)  m_perr[u] = 1'b1;
            m_nb[u] = 0;
            return;
        end
        if (m_nb[u] == 0) begin
            m_b0[u] = d;
            m_nb[u] = 1;
        end else begin
            m_nb[u] = 0;
            if (m_words[u] < m_depth[u]) begin
                exp_q.push_back({2'(u), 8'(1 + m_words[u]), m_b0[u], d});
                m_max[u] = 8'(1 + m_words[u]);
                m_words[u]++;
            end else begin
                m_ovf[u] = 1'b1;
            end
        end
    endtask

    task automatic frame(input int u, input logic [7:0] d, input bit par_en,
                         input bit par, input bit stop);
        model_byte(u, d, stop, par_en && (par != (^d)));
        rx[u] = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx[u] = d[i];
            repeat (CPB) tick();
        end
        if (par_en) begin
            rx[u] = par;
            repeat (CPB) tick();
        end
        rx[u] = stop;
        repeat (CPB) tick();
        rx[u] = 1'b1;
        if (!stop) repeat (CPB) tick();
    endtask

    task automatic send(input int u, input logic [7:0] d);
        frame(u, d, (u == 1), ^d, 1'b1);
    endtask

    task automatic check_state(input int u);
        chk($sformatf("max_addr_u%0d", u),   {24'd0, maxa[u]}, {24'd0, m_max[u]});
        chk($sformatf("frame_err_u%0d", u),  {31'd0, ferr[u]}, {31'd0, m_ferr[u]});
        chk($sformatf("parity_err_u%0d", u), {31'd0, perr[u]}, {31'd0, m_perr[u]});
        chk($sformatf("overflow_u%0d", u),   {31'd0, ovf[u]},  {31'd0, m_ovf[u]});
        chk($sformatf("done_u%0d", u),       {31'd0, done[u]}, {31'd0, m_done[u]});
    endtask

    task automatic wait_done(input int u, input bit timed);
        int start;
        int dly;
        start = cyc;
        while (done[u] !== 1'b1 && (cyc - start) < 3 * TOUT) tick();
        chk($sformatf("done_rise_u%0d", u), {31'd0, done[u]}, 32'd1);
        if (timed) begin
            dly = cyc - last_we[u];
            tests++;
            if (dly < TOUT || dly > TOUT + 2) begin
                fails++;
                $display("FAIL done_delay_u%0d: got %0d cycles after last write, required %0d..%0d",
                         u, dly, TOUT, TOUT + 2);
            end
        end
        if (m_words[u] > 0) begin
            m_done[u] = 1'b1;
            m_nb[u]   = 0;
        end
    endtask

    task automatic do_clear(input int u);
        clr[u] = 1'b1;
        tick();
        clr[u] = 1'b0;
        model_clear(u);
        tick();
        check_state(u);
        chk($sformatf("clear_addr_u%0d", u), {24'd0, addr[u]}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        rx    = 3'b111;
        clr   = 3'b000;
        for (int u = 0; u < 3; u++) begin
            model_clear(u);
            nwr[u]     = 0;
            last_we[u] = 0;
        end
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        for (int u = 0; u < 3; u++) begin
            check_state(u);
            chk($sformatf("rst_we_u%0d", u),    {31'd0, we[u]},   32'd0);
            chk($sformatf("rst_addr_u%0d", u),  {24'd0, addr[u]}, 32'd0);
            chk($sformatf("rst_wdata_u%0d", u), {16'd0, wd[u]},   32'd0);
        end

        // An idle gap with nothing written must not complete the download
        repeat (TOUT + 20) tick();
        chk("idle_no_words_done", {31'd0, done[0]}, 32'd0);

        // Full 22-byte download
        base = nwr[0];
        for (int i = 0; i < 22; i++) send(0, seq[i]);
        wait_done(0, 1'b1);
        check_state(0);
        chk("dl_writes",     32'(nwr[0] - base), 32'd11);
        chk("dl_first_word", {16'd0, wlog[0][base]},      32'h4126);
        chk("dl_last_word",  {16'd0, wlog[0][base + 10]}, 32'hE000);
        chk("dl_max_addr",   {24'd0, maxa[0]},            32'd11);

        // Traffic after completion is ignored
        send(0, 8'h55);
        send(0, 8'h66);
        repeat (CPB) tick();
        chk("after_done_writes", 32'(nwr[0] - base), 32'd11);
        check_state(0);

        // Short glitch is a false start, then a framing error, then a good word
        do_clear(0);
        rx[0] = 1'b0;
        repeat (3) tick();
        rx[0] = 1'b1;
        repeat (2 * CPB) tick();
        check_state(0);
        base = nwr[0];
        frame(0, 8'h41, 1'b0, 1'b0, 1'b0);
        send(0, 8'h41);
        send(0, 8'h00);
        wait_done(0, 1'b1);
        check_state(0);
        chk("ferr_writes",   32'(nwr[0] - base), 32'd1);
        chk("ferr_word",     {16'd0, wlog[0][base]}, 32'h4100);
        chk("ferr_flag",     {31'd0, ferr[0]}, 32'd1);
        chk("ferr_max_addr", {24'd0, maxa[0]}, 32'd1);

        // Even parity: wrong parity bit drops the byte
        base = nwr[1];
        frame(1, 8'h41, 1'b1, 1'b1, 1'b1);
        send(1, 8'h12);
        send(1, 8'h34);
        wait_done(1, 1'b1);
        check_state(1);
        chk("par_writes", 32'(nwr[1] - base), 32'd1);
        chk("par_word",   {16'd0, wlog[1][base]}, 32'h1234);
        chk("par_flag",   {31'd0, perr[1]}, 32'd1);
        chk("par_ferr",   {31'd0, ferr[1]}, 32'd0);

        // Depth of two words: third word overflows
        base = nwr[2];
        send(2, 8'hAA); send(2, 8'hBB);
        send(2, 8'hCC); send(2, 8'hDD);
        send(2, 8'hEE); send(2, 8'hFF);
        wait_done(2, 1'b0);
        check_state(2);
        chk("ovf_writes",   32'(nwr[2] - base), 32'd2);
        chk("ovf_flag",     {31'd0, ovf[2]},  32'd1);
        chk("ovf_max_addr", {24'd0, maxa[2]}, 32'd2);

        // Reset in the middle of a byte
        rx[0] = 1'b0;
        repeat (3 * CPB) tick();
        rst_n = 1'b0;
        rx[0] = 1'b1;
        for (int u = 0; u < 3; u++) model_clear(u);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        for (int u = 0; u < 3; u++) check_state(u);
        base = nwr[0];
        send(0, 8'h41);
        send(0, 8'h00);
        wait_done(0, 1'b1);
        check_state(0);
        chk("rst_writes",   32'(nwr[0] - base), 32'd1);
        chk("rst_max_addr", {24'd0, maxa[0]}, 32'd1);

        // Same sequence after a synchronous re-arm
        do_clear(0);
        base = nwr[0];
        send(0, 8'h41);
        send(0, 8'h00);
        wait_done(0, 1'b1);
        check_state(0);
        chk("clr_writes",   32'(nwr[0] - base), 32'd1);
        chk("clr_word",     {16'd0, wlog[0][base]}, 32'h4100);
        chk("clr_max_addr", {24'd0, maxa[0]}, 32'd1);

        repeat (10) tick();
        chk("pending_writes", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
